// File: rtl/decimal_entry.sv
// Operator entry path: debounced inc/wr buttons edit a BCD value one digit at a time,
// and a commit converts it to binary and offers it on a valid/ready handshake.

module decimal_entry_db #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pulse
);

  localparam int CW = $clog2(DB_CYCLES) + 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_cnt;

  // The counter only advances while the synchronized level disagrees with the debounced one,
  // so any return to the old level restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_db & ~r_db_q;

endmodule

module decimal_entry #(
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 16,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic             inc,
  input  logic             wr,
  output logic [3:0]       digit_out,
  output logic [WIDTH-1:0] bin_data,
  output logic             bin_valid,
  input  logic             bin_ready
);

  // One extra index bit: the conversion is finished once the index wraps below zero.
  localparam int IW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_inc_p;
  logic             w_wr_p;
  logic [1:0]       w_didx;
  logic             w_conv_done;
  logic [3:0]       r_dig  [DIGITS];
  logic [3:0]       r_snap [DIGITS];
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_bin;
  logic [IW-1:0]    r_idx;

  function automatic logic [3:0] f_bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [WIDTH-1:0] f_mac10(input logic [WIDTH-1:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + WIDTH'(d);
  endfunction

  decimal_entry_db #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst_n   (reset),
    .i_raw   (inc),
    .o_pulse (w_inc_p)
  );

  decimal_entry_db #(.DB_CYCLES(DB_CYCLES)) u_db_wr (
    .clk     (clk),
    .rst_n   (reset),
    .i_raw   (wr),
    .o_pulse (w_wr_p)
  );

  // sel 00 addresses the most significant digit, 11 the ones digit.
  assign w_didx      = 2'(DIGITS - 1) - sel;
  assign w_conv_done = r_idx[IW-1];
  assign digit_out   = r_dig[w_didx];
  assign bin_data    = r_bin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (w_inc_p) begin
      r_dig[w_didx] <= f_bcd_inc(r_dig[w_didx]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_wr_p)      w_state_nxt = S_CONVERT;
      S_CONVERT: if (w_conv_done) w_state_nxt = S_VALID;
      S_VALID:   if (bin_ready)   w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bin_valid = 1'b0;
    if (r_state == S_VALID) bin_valid = 1'b1;
  end

  // The snapshot isolates the conversion from live edits made while it runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIGITS; i++) r_snap[i] <= 4'd0;
      r_acc <= '0;
      r_idx <= '0;
      r_bin <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_p) begin
            for (int i = 0; i < DIGITS; i++) r_snap[i] <= r_dig[i];
            r_acc <= '0;
            r_idx <= IW'(DIGITS - 1);
          end
        end
        S_CONVERT: begin
          if (!w_conv_done) begin
            r_acc <= f_mac10(r_acc, r_snap[r_idx[IW-2:0]]);
            r_idx <= r_idx - 1'b1;
          end else begin
            r_bin <= r_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_entry.sv
// Randomized bench for decimal_entry: button presses with bounce feed a digit-array model,
// commits push expected values into a scoreboard that a negedge monitor drains.
`timescale 1ns/1ps

module tb_decimal_entry;

  localparam int DIGITS = 4;
  localparam int DB     = 16;
  localparam int WIDTH  = 32;
  localparam int LAT    = DB + DIGITS + 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       sel = 2'd0;
  logic             inc = 1'b0;
  logic             wr = 1'b0;
  logic             bin_ready = 1'b0;
  logic [3:0]       digit_out;
  logic [WIDTH-1:0] bin_data;
  logic             bin_valid;

  decimal_entry #(.DIGITS(DIGITS), .DB_CYCLES(DB), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset_n),
    .sel       (sel),
    .inc       (inc),
    .wr        (wr),
    .digit_out (digit_out),
    .bin_data  (bin_data),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    longint      at_edge;
  } exp_t;

  exp_t   q[$];
  int     model_dig[DIGITS];
  bit     model_busy = 1'b0;
  int     n_cmp = 0;
  int     n_err = 0;
  longint edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] model_value();
    longint v = 0;
    longint p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      v += longint'(model_dig[k]) * p;
      p *= 10;
    end
    return v[31:0];
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit is_wr, input bit v);
    if (is_wr) wr = v;
    else       inc = v;
  endtask

  // One button press: nb short bounces, then a clean hold, then a full release.
  task automatic press(input bit is_wr, input int s, input int hold, input int nb);
    if (!is_wr) sel = 2'(s);
    for (int b = 0; b < nb; b++) begin
      set_line(is_wr, 1'b1);
      tick($urandom_range(DB - 1, 1));
      set_line(is_wr, 1'b0);
      tick($urandom_range(4, 1));
    end
    if (is_wr) begin
      if (!model_busy) begin
        q.push_back('{model_value(), edge_cnt + LAT});
        model_busy = 1'b1;
      end
    end else if (hold >= DB) begin
      model_dig[DIGITS - 1 - s] = (model_dig[DIGITS - 1 - s] + 1) % 10;
    end
    set_line(is_wr, 1'b1);
    tick(hold);
    set_line(is_wr, 1'b0);
    tick(DB + 6);
  endtask

  task automatic check_digits();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check(digit_out == 4'(model_dig[DIGITS - 1 - s]), $sformatf("digit_sel%0d", s),
            longint'(digit_out), longint'(model_dig[DIGITS - 1 - s]));
    end
  endtask

  task automatic set_digit(input int s, input int v);
    while (model_dig[DIGITS - 1 - s] != v)
      press(1'b0, s, $urandom_range(DB + 6, DB), $urandom_range(2, 0));
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (model_busy && c < maxc) begin
      tick(1);
      c++;
    end
    if (model_busy) begin
      check(1'b0, "idle_timeout", longint'(c), longint'(maxc));
      model_busy = 1'b0;
      q.delete();
    end
  endtask

  task automatic commit(input int ready_delay, input int nb);
    int c = 0;
    bin_ready = (ready_delay == 0);
    press(1'b1, 0, $urandom_range(DB + 4, DB), nb);
    if (ready_delay > 0) begin
      while (!bin_valid && c < 100) begin
        tick(1);
        c++;
      end
      tick(ready_delay);
      bin_ready = 1'b1;
    end
    wait_idle(200);
  endtask

  // Scoreboard monitor: pops one expectation per rising bin_valid and checks the
  // value, the commit latency, stability while held and release after the handshake.
  bit          prev_v = 1'b0;
  bit          exp_drop = 1'b0;
  logic [31:0] held = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v   = 1'b0;
      exp_drop = 1'b0;
    end else begin
      if (exp_drop) begin
        check(!bin_valid, "valid_drop", longint'(bin_valid), 0);
        exp_drop = 1'b0;
        if (!bin_valid) model_busy = 1'b0;
      end
      if (bin_valid && !prev_v) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_valid", longint'(bin_data), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check(bin_data == e.val, "bin_data", longint'(bin_data), longint'(e.val));
          check(edge_cnt == e.at_edge, "commit_latency", edge_cnt, e.at_edge);
        end
        held = bin_data;
      end else if (bin_valid) begin
        check(bin_data == held, "data_hold", longint'(bin_data), longint'(held));
      end
      if (bin_valid && bin_ready) exp_drop = 1'b1;
      prev_v = bin_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DIGITS; k++) model_dig[k] = 0;

    tick(3);
    check(!bin_valid, "reset_valid", longint'(bin_valid), 0);
    check(bin_data == 0, "reset_data", longint'(bin_data), 0);
    check_digits();
    reset_n = 1'b1;
    tick(3);

    // Ones digit walks 1..9 then wraps to 0; others stay 0.
    for (int i = 0; i < 10; i++) begin
      press(1'b0, 3, DB + 2, 0);
      check_digits();
    end

    // A glitch one cycle short of the debounce window is ignored.
    sel = 2'd3;
    inc = 1'b1;
    tick(DB - 1);
    inc = 1'b0;
    tick(DB + 6);
    check_digits();
    press(1'b0, 3, DB + 2, 0);
    check_digits();

    // 1234 with ready already high: one-cycle valid pulse.
    set_digit(0, 1);
    set_digit(1, 2);
    set_digit(2, 3);
    set_digit(3, 4);
    check_digits();
    commit(0, 0);

    // Edits and a second wr during a conversion do not disturb the result.
    bin_ready = 1'b0;
    fork
      press(1'b1, 0, DB + 2, 0);
      begin
        tick(2);
        press(1'b0, 3, DB + 2, 0);
      end
    join
    press(1'b1, 0, DB + 2, 0);
    bin_ready = 1'b1;
    wait_idle(100);
    check_digits();

    // 9999 held for 20 cycles with ready low.
    for (int s = 0; s < 4; s++) set_digit(s, 9);
    bin_ready = 1'b0;
    press(1'b1, 0, DB + 2, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check(bin_valid, "valid_held", longint'(bin_valid), 1);
    end
    check(bin_data == 32'h0000270F, "data_9999", longint'(bin_data), 32'h270F);
    bin_ready = 1'b1;
    tick(1);
    check(!bin_valid, "valid_release", longint'(bin_valid), 0);
    check(bin_data == 32'h0000270F, "data_kept", longint'(bin_data), 32'h270F);
    wait_idle(50);

    // Reset two cycles into the conversion aborts it and clears the digits.
    fork
      press(1'b1, 0, DB + 1, 0);
      begin
        tick(LAT - 3);
        reset_n = 1'b0;
        q.delete();
        model_busy = 1'b0;
        for (int k = 0; k < DIGITS; k++) model_dig[k] = 0;
        #1;
        check(!bin_valid, "abort_valid", longint'(bin_valid), 0);
        tick(2);
        check_digits();
        reset_n = 1'b1;
      end
    join
    tick(5);
    check(!bin_valid, "post_abort_valid", longint'(bin_valid), 0);
    check_digits();
    commit(0, 0);

    // Randomized edits, near-threshold presses, bounce and handshake delays.
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(4, 0);
      for (int j = 0; j < n; j++)
        press(1'b0, $urandom_range(3, 0), $urandom_range(DB + 6, DB - 3), $urandom_range(2, 0));
      check_digits();
      commit(($urandom_range(1, 0) == 1) ? $urandom_range(15, 1) : 0, $urandom_range(2, 0));
    end

    tick(10);
    check(q.size() == 0, "queue_empty", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
